picorv32_freeahb_adapter: RTL and testbench
===========================================

PICORV32_FREEAHB_ADAPTER -- requirements
Module: picorv32_freeahb_adapter

Interface
REQ-001 Parameter BIG_ENDIAN_AHB, default 0: 0 = little-endian byte lanes; 1 = byte-swap data in both directions.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 enable  in  1  when high, new PicoRV32 requests are accepted.
REQ-005 PicoRV32 side inputs: mem_valid 1, mem_instr 1 (instruction fetch), mem_addr 32, mem_wdata 32, mem_wstrb 4 (0 = read).
REQ-006 PicoRV32 side outputs: mem_rdata 32 (read data), mem_ready 1 (transfer complete).
REQ-007 FreeAHB UI outputs: freeahb_valid 1, freeahb_read 1, freeahb_write 1, freeahb_addr 32, freeahb_wdata 32, freeahb_size 3, freeahb_min_len 32, freeahb_cont 1, freeahb_prot 4, freeahb_lock 1.
REQ-008 FreeAHB UI inputs: freeahb_next 1 (command accepted), freeahb_ready 1 (freeahb_rdata valid), freeahb_rdata 32, freeahb_result_addr 32 (ignored).

Function
REQ-009 States: IDLE, READ, WRITE, RESP.
REQ-010 IDLE: if enable and mem_valid, register addr, size, wdata and prot, then go to READ when mem_wstrb = 0, else WRITE; otherwise stay in IDLE.
REQ-011 READ: drive freeahb_read = 1 and freeahb_valid = 1 until freeahb_next is sampled high, then drive both to 0 while waiting.
REQ-012 READ exit: on the first edge with freeahb_ready = 1, latch freeahb_rdata (byte-swapped if BIG_ENDIAN_AHB) into mem_rdata and go to RESP; freeahb_next is not required for read completion.
REQ-013 WRITE: drive freeahb_write = 1 and freeahb_valid = 1 with freeahb_wdata = mem_wdata (byte-swapped if BIG_ENDIAN_AHB); hold until freeahb_next is sampled high, then go to RESP.
REQ-014 RESP: mem_ready = 1 for exactly one cycle, freeahb_read, freeahb_write and freeahb_valid = 0, then go to IDLE.
REQ-015 mem_ready is registered and is high only in RESP; mem_rdata holds its last value until the next read completes.
REQ-016 Size and address from wstrb: 1111 -> size 3'b010, addr = mem_addr.
REQ-017 Size and address from wstrb: 0011 -> size 3'b001, +0; 1100 -> size 3'b001, +2.
REQ-018 Size and address from wstrb: single bit k -> size 3'b000, addr = mem_addr + k.
REQ-019 Any other nonzero wstrb -> size 3'b010, aligned word address.
REQ-020 Reads always use size 3'b010 and addr = {mem_addr[31:2], 2'b00}.
REQ-021 Constant outputs: freeahb_min_len = 0, freeahb_cont = 0, freeahb_lock = 0.
REQ-022 freeahb_prot = {1'b0, 1'b0, 1'b1, ~mem_instr}: privileged; bit0 = 1 for data access, 0 for opcode fetch.
REQ-023 UI outputs are stable throughout READ and WRITE; they change only on state transitions or on the edge freeahb_next is sampled.
REQ-024 enable low blocks only new starts; a transfer already in READ or WRITE completes normally.
REQ-025 freeahb_ready is ignored outside READ; freeahb_next is ignored outside READ and WRITE.
REQ-026 The design is fully synchronous apart from reset; there are no combinational paths from inputs to mem_ready.

Reset
REQ-027 resetn low asynchronously forces state IDLE and all outputs to 0, including mem_rdata and freeahb_addr.
REQ-028 Reset mid-transfer abandons the transfer; no mem_ready is issued for it.
REQ-029 After resetn deasserts, the first request is accepted on the next edge with enable and mem_valid high.

Verification
REQ-030 Read: mem_addr = 0x80000000, mem_valid = 1, mem_wstrb = 0, mem_instr = 0 -> freeahb_read = 1, addr 0x80000000, size 010, prot 4'b0011; then freeahb_ready = 1 with rdata 0xAAAAFFFF -> one-cycle mem_ready, mem_rdata = 0xAAAAFFFF.
REQ-031 Halfword write: mem_addr = 0x80000000, wdata = 0xF0FF0FAA, wstrb = 1100, mem_instr = 1 -> freeahb_write = 1, addr 0x80000002, size 001, prot 4'b0010, held until freeahb_next = 1 -> one mem_ready pulse, then write = 0.
REQ-032 Write with freeahb_next held low for 10 cycles -> write, valid and addr stay constant; mem_ready stays 0.
REQ-033 enable = 0 with mem_valid = 1 -> no freeahb_read or freeahb_write for 10 cycles; raising enable starts the transfer on the next edge.
REQ-034 BIG_ENDIAN_AHB = 1, read returning 0x11223344 -> mem_rdata = 0x44332211; word write of 0x11223344 -> freeahb_wdata = 0x44332211.
REQ-035 resetn pulsed low during WRITE -> all outputs 0 immediately; no mem_ready; the next request proceeds normally.

Source files
------------

// File: rtl/picorv32_freeahb_adapter.sv
// picorv32_freeahb_adapter
// Bridges the PicoRV32 native memory interface onto the FreeAHB master user
// interface. One transfer at a time: a request is captured in IDLE, issued
// as a FreeAHB read or write, and acknowledged to the core with a
// single-cycle registered mem_ready.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   enable                 allows new requests to start
//   mem_*                  PicoRV32 native memory port (request in, rdata/ready out)
//   freeahb_valid/read/write/addr/wdata/size/min_len/cont/prot/lock
//                          FreeAHB UI command outputs (all registered)
//   freeahb_next           command accepted by FreeAHB
//   freeahb_ready/rdata    read data return
//   freeahb_result_addr    unused
module picorv32_freeahb_adapter #(
  parameter bit BIG_ENDIAN_AHB = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        freeahb_valid,
  output logic        freeahb_read,
  output logic        freeahb_write,
  output logic [31:0] freeahb_addr,
  output logic [31:0] freeahb_wdata,
  output logic [2:0]  freeahb_size,
  output logic [31:0] freeahb_min_len,
  output logic        freeahb_cont,
  output logic [3:0]  freeahb_prot,
  output logic        freeahb_lock,
  input  logic        freeahb_next,
  input  logic        freeahb_ready,
  input  logic [31:0] freeahb_rdata,
  input  logic [31:0] freeahb_result_addr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;
  logic [3:0]  prot_q, prot_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;

  logic [31:0] req_addr;
  logic [2:0]  req_size;

  // The result address is not needed for single transfers.
  logic unused_result_addr;
  assign unused_result_addr = ^freeahb_result_addr;

  function automatic logic [31:0] lane_swap(input logic [31:0] d);
    return BIG_ENDIAN_AHB ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
  endfunction

  // Narrow writes become byte/halfword AHB transfers at the lane's address;
  // irregular strobe patterns fall back to an aligned word.
  always_comb begin
    req_size = 3'b010;
    req_addr = {mem_addr[31:2], 2'b00};
    case (mem_wstrb)
      4'b1111: begin req_size = 3'b010; req_addr = mem_addr;          end
      4'b0011: begin req_size = 3'b001; req_addr = mem_addr;          end
      4'b1100: begin req_size = 3'b001; req_addr = mem_addr + 32'd2;  end
      4'b0001: begin req_size = 3'b000; req_addr = mem_addr;          end
      4'b0010: begin req_size = 3'b000; req_addr = mem_addr + 32'd1;  end
      4'b0100: begin req_size = 3'b000; req_addr = mem_addr + 32'd2;  end
      4'b1000: begin req_size = 3'b000; req_addr = mem_addr + 32'd3;  end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    read_d  = read_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    prot_d  = prot_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && mem_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          wdata_d = lane_swap(mem_wdata);
          prot_d  = {2'b00, 1'b1, ~mem_instr};
          valid_d = 1'b1;
          if (mem_wstrb == 4'b0000) begin
            read_d  = 1'b1;
            state_d = READ;
          end else begin
            write_d = 1'b1;
            state_d = WRITE;
          end
        end
      end
      READ: begin
        // Data may return without a visible next; ready alone completes.
        if (freeahb_ready) begin
          rdata_d = lane_swap(freeahb_rdata);
          valid_d = 1'b0;
          read_d  = 1'b0;
          ready_d = 1'b1;
          state_d = RESP;
        end else if (freeahb_next) begin
          valid_d = 1'b0;
          read_d  = 1'b0;
        end
      end
      WRITE: begin
        if (freeahb_next) begin
          valid_d = 1'b0;
          write_d = 1'b0;
          ready_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      prot_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      prot_q  <= prot_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  assign mem_rdata       = rdata_q;
  assign mem_ready       = ready_q;
  assign freeahb_valid   = valid_q;
  assign freeahb_read    = read_q;
  assign freeahb_write   = write_q;
  assign freeahb_addr    = addr_q;
  assign freeahb_wdata   = wdata_q;
  assign freeahb_size    = size_q;
  assign freeahb_prot    = prot_q;
  assign freeahb_min_len = 32'd0;
  assign freeahb_cont    = 1'b0;
  assign freeahb_lock    = 1'b0;

endmodule

// File: tb/tb_picorv32_freeahb_adapter.sv
// Directed bench for picorv32_freeahb_adapter. Two instances share all
// inputs: one little-endian, one byte-swapping. Expected read data for each
// completed transfer is queued when the transfer is launched and compared
// when mem_ready is seen.
module tb_picorv32_freeahb_adapter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        freeahb_next;
  logic        freeahb_ready;
  logic [31:0] freeahb_rdata;
  logic [31:0] freeahb_result_addr;

  logic [31:0] mem_rdata, mem_rdata_be;
  logic        mem_ready, mem_ready_be;
  logic        freeahb_valid, freeahb_valid_be;
  logic        freeahb_read, freeahb_read_be;
  logic        freeahb_write, freeahb_write_be;
  logic [31:0] freeahb_addr, freeahb_addr_be;
  logic [31:0] freeahb_wdata, freeahb_wdata_be;
  logic [2:0]  freeahb_size, freeahb_size_be;
  logic [31:0] freeahb_min_len, freeahb_min_len_be;
  logic        freeahb_cont, freeahb_cont_be;
  logic [3:0]  freeahb_prot, freeahb_prot_be;
  logic        freeahb_lock, freeahb_lock_be;

  typedef struct {
    logic [31:0] le;
    logic [31:0] be;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_le, last_be;
  int          checks = 0;
  int          errors = 0;

  logic [3:0]  tbl_strb [9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hF, 4'h5, 4'h6, 4'h9};
  logic [31:0] tbl_off  [9] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
  logic [2:0]  tbl_size [9] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2};

  always #5 clk = ~clk;

  picorv32_freeahb_adapter #(.BIG_ENDIAN_AHB(1'b0)) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .freeahb_valid(freeahb_valid), .freeahb_read(freeahb_read),
    .freeahb_write(freeahb_write), .freeahb_addr(freeahb_addr),
    .freeahb_wdata(freeahb_wdata), .freeahb_size(freeahb_size),
    .freeahb_min_len(freeahb_min_len), .freeahb_cont(freeahb_cont),
    .freeahb_prot(freeahb_prot), .freeahb_lock(freeahb_lock),
    .freeahb_next(freeahb_next), .freeahb_ready(freeahb_ready),
    .freeahb_rdata(freeahb_rdata), .freeahb_result_addr(freeahb_result_addr)
  );

  picorv32_freeahb_adapter #(.BIG_ENDIAN_AHB(1'b1)) dut_be (
    .clk(clk), .resetn(resetn), .enable(enable),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata_be), .mem_ready(mem_ready_be),
    .freeahb_valid(freeahb_valid_be), .freeahb_read(freeahb_read_be),
    .freeahb_write(freeahb_write_be), .freeahb_addr(freeahb_addr_be),
    .freeahb_wdata(freeahb_wdata_be), .freeahb_size(freeahb_size_be),
    .freeahb_min_len(freeahb_min_len_be), .freeahb_cont(freeahb_cont_be),
    .freeahb_prot(freeahb_prot_be), .freeahb_lock(freeahb_lock_be),
    .freeahb_next(freeahb_next), .freeahb_ready(freeahb_ready),
    .freeahb_rdata(freeahb_rdata), .freeahb_result_addr(freeahb_result_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for mem_ready, pops the scoreboard and checks read data,
  // then checks that the pulse lasted exactly one cycle.
  task automatic expect_ready(input string tag);
    int   n = 0;
    exp_t e;
    while (mem_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(mem_ready), 32'd1);
    chk({tag, "_ready_be"}, 32'(mem_ready_be), 32'd1);
    mem_valid     = 1'b0;
    freeahb_ready = 1'b0;
    freeahb_next  = 1'b0;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_rdata"}, mem_rdata, e.le);
      chk({tag, "_rdata_be"}, mem_rdata_be, e.be);
    end else begin
      checks++;
      errors++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(mem_ready), 32'd0);
    $display("txn %s: rdata=%h rdata_be=%h cycles=%0d", tag, mem_rdata, mem_rdata_be, n);
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    freeahb_next = 1'b0; freeahb_ready = 1'b0; freeahb_rdata = '0;
    freeahb_result_addr = 32'h1234_5678;
    last_le = '0; last_be = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_valid", 32'(freeahb_valid), 32'd0);
    chk("rst_read", 32'(freeahb_read), 32'd0);
    chk("rst_write", 32'(freeahb_write), 32'd0);
    chk("rst_addr", freeahb_addr, 32'd0);
    chk("rst_wdata", freeahb_wdata, 32'd0);
    chk("rst_size", 32'(freeahb_size), 32'd0);
    chk("rst_prot", 32'(freeahb_prot), 32'd0);
    chk("rst_min_len", freeahb_min_len, 32'd0);
    chk("rst_cont", 32'(freeahb_cont), 32'd0);
    chk("rst_lock", 32'(freeahb_lock), 32'd0);
    resetn = 1'b1;
    enable = 1'b1;

    // Data read
    mem_valid = 1'b1; mem_addr = 32'h8000_0000; mem_wstrb = 4'b0000; mem_instr = 1'b0;
    @(negedge clk);
    chk("rd_read", 32'(freeahb_read), 32'd1);
    chk("rd_valid", 32'(freeahb_valid), 32'd1);
    chk("rd_write", 32'(freeahb_write), 32'd0);
    chk("rd_addr", freeahb_addr, 32'h8000_0000);
    chk("rd_size", 32'(freeahb_size), 32'd2);
    chk("rd_prot", 32'(freeahb_prot), 32'h3);
    chk("rd_ready_early", 32'(mem_ready), 32'd0);
    freeahb_next = 1'b1;
    @(negedge clk);
    chk("rd_valid_after_next", 32'(freeahb_valid), 32'd0);
    chk("rd_read_after_next", 32'(freeahb_read), 32'd0);
    chk("rd_wait_ready", 32'(mem_ready), 32'd0);
    freeahb_next = 1'b0;
    freeahb_ready = 1'b1; freeahb_rdata = 32'hAAAA_FFFF;
    last_le = 32'hAAAA_FFFF; last_be = 32'hFFFF_AAAA;
    sb_q.push_back('{last_le, last_be});
    expect_ready("read1");

    // Halfword write from an instruction-tagged request, next held off
    mem_valid = 1'b1; mem_addr = 32'h8000_0000; mem_wdata = 32'hF0FF_0FAA;
    mem_wstrb = 4'b1100; mem_instr = 1'b1;
    @(negedge clk);
    chk("hw_write", 32'(freeahb_write), 32'd1);
    chk("hw_read", 32'(freeahb_read), 32'd0);
    chk("hw_addr", freeahb_addr, 32'h8000_0002);
    chk("hw_size", 32'(freeahb_size), 32'd1);
    chk("hw_prot", 32'(freeahb_prot), 32'h2);
    chk("hw_wdata", freeahb_wdata, 32'hF0FF_0FAA);
    chk("hw_wdata_be", freeahb_wdata_be, 32'hAA0F_FFF0);
    // Stray read-data strobe during a write must be ignored.
    freeahb_ready = 1'b1; freeahb_rdata = 32'h5555_5555;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_write", 32'(freeahb_write), 32'd1);
      chk("hold_valid", 32'(freeahb_valid), 32'd1);
      chk("hold_addr", freeahb_addr, 32'h8000_0002);
      chk("hold_ready", 32'(mem_ready), 32'd0);
    end
    freeahb_ready = 1'b0;
    freeahb_next = 1'b1;
    sb_q.push_back('{last_le, last_be});
    expect_ready("write_hw");
    chk("hw_write_done", 32'(freeahb_write), 32'd0);

    // Enable low blocks new requests
    enable = 1'b0;
    mem_valid = 1'b1; mem_addr = 32'h1000_0006; mem_wstrb = 4'b0000; mem_instr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("blk_read", 32'(freeahb_read), 32'd0);
      chk("blk_write", 32'(freeahb_write), 32'd0);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("en_read", 32'(freeahb_read), 32'd1);
    chk("en_addr", freeahb_addr, 32'h1000_0004);
    chk("en_prot", 32'(freeahb_prot), 32'h2);
    // Read completes on ready alone, no next.
    freeahb_ready = 1'b1; freeahb_rdata = 32'h1122_3344;
    last_le = 32'h1122_3344; last_be = 32'h4433_2211;
    sb_q.push_back('{last_le, last_be});
    expect_ready("read_en");

    // Strobe-to-size/address mapping
    for (int i = 0; i < 9; i++) begin
      mem_valid = 1'b1; mem_addr = 32'h2000_0010; mem_wdata = 32'h1122_3344;
      mem_wstrb = tbl_strb[i]; mem_instr = 1'b0;
      @(negedge clk);
      chk("strb_write", 32'(freeahb_write), 32'd1);
      chk("strb_addr", freeahb_addr, 32'h2000_0010 + tbl_off[i]);
      chk("strb_size", 32'(freeahb_size), 32'(tbl_size[i]));
      chk("strb_wdata", freeahb_wdata, 32'h1122_3344);
      chk("strb_wdata_be", freeahb_wdata_be, 32'h4433_2211);
      freeahb_next = 1'b1;
      sb_q.push_back('{last_le, last_be});
      expect_ready("write_strb");
    end

    // Reset during a write
    mem_valid = 1'b1; mem_addr = 32'h3000_0000; mem_wdata = 32'hCAFE_F00D;
    mem_wstrb = 4'b1111; mem_instr = 1'b0;
    @(negedge clk);
    chk("rw_write", 32'(freeahb_write), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rw_write_rst", 32'(freeahb_write), 32'd0);
    chk("rw_valid_rst", 32'(freeahb_valid), 32'd0);
    chk("rw_addr_rst", freeahb_addr, 32'd0);
    chk("rw_rdata_rst", mem_rdata, 32'd0);
    chk("rw_ready_rst", 32'(mem_ready), 32'd0);
    mem_valid = 1'b0;
    freeahb_next = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rw_no_ready", 32'(mem_ready), 32'd0);
    end
    freeahb_next = 1'b0;
    resetn = 1'b1;
    last_le = '0; last_be = '0;
    @(negedge clk);
    chk("rw_idle_ready", 32'(mem_ready), 32'd0);
    mem_valid = 1'b1; mem_addr = 32'h0000_0040; mem_wstrb = 4'b0000; mem_instr = 1'b0;
    @(negedge clk);
    chk("post_read", 32'(freeahb_read), 32'd1);
    chk("post_addr", freeahb_addr, 32'h0000_0040);
    freeahb_ready = 1'b1; freeahb_rdata = 32'hDEAD_BEEF;
    last_le = 32'hDEAD_BEEF; last_be = 32'hEFBE_ADDE;
    sb_q.push_back('{last_le, last_be});
    expect_ready("read_post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
